// File: rtl/gate_vector_sequencer_if.sv
// Sequencer <-> bench/gate bus; master is the sequencer side, slave the controller/gate side.
// No handshake: start is a level sampled only while idle, results are held until the next run.
interface gate_vector_sequencer_if #(
    parameter int unsigned N_INPUTS = 2
);
    logic                start;
    logic                dut_y;
    logic [N_INPUTS-1:0] vec_out;
    logic                vec_valid;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   err_count;
    logic                fail_seen;
    logic [N_INPUTS-1:0] fail_vec;

    modport master (
        input  start, dut_y,
        output vec_out, vec_valid, busy, done, pass, err_count, fail_seen, fail_vec
    );

    modport slave (
        output start, dut_y,
        input  vec_out, vec_valid, busy, done, pass, err_count, fail_seen, fail_vec
    );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Sweeps every input vector into a gate, checks dut_y against EXPECT_TT; GATE_SEQ_STOP_ON_FAIL_EN ends a run on its first mismatch.
// Latency: done rises 1+2^N*(HOLD_CYCLES+1) cycles after start; start is ignored while busy, no backpressure.
module gate_vector_sequencer #(
    parameter int unsigned                  N_INPUTS    = 2,
    parameter int unsigned                  HOLD_CYCLES = 1,
    parameter logic [(2**N_INPUTS)-1:0]     EXPECT_TT   = 4'b1000
) (
    input  logic                     clk,
    input  logic                     rst,
    gate_vector_sequencer_if.master  bus
);
    localparam int unsigned       NVEC      = 1 << N_INPUTS;
    localparam logic [N_INPUTS:0] ERR_MAX   = NVEC[N_INPUTS:0];
    localparam logic [N_INPUTS:0] ERR_ONE   = 1;
    localparam logic [N_INPUTS-1:0] VEC_ONE = 1;
    localparam logic [7:0]        HOLD_INIT = HOLD_CYCLES[7:0];

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state_q;
    logic [N_INPUTS-1:0] vec_q;
    logic [N_INPUTS-1:0] fail_vec_q;
    logic [N_INPUTS:0]   err_q;
    logic [7:0]          hold_q;
    logic                vld_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                fail_seen_q;

    logic                mismatch_d;
    logic                last_vec_d;
    logic [N_INPUTS:0]   err_d;
    state_t              first_state_d;

    always_comb begin
        mismatch_d    = bus.dut_y != EXPECT_TT[vec_q];
        last_vec_d    = &vec_q;
        err_d         = err_q;
        if (mismatch_d && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_ONE;
        end
        first_state_d = (HOLD_CYCLES == 0) ? SAMPLE : SETTLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            fail_vec_q  <= '0;
            err_q       <= '0;
            hold_q      <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // Result flags settle one cycle after entering DONE; a start here overrides them.
                    if (state_q == DONE) begin
                        busy_q <= 1'b0;
                        vld_q  <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                    end
                    if (bus.start) begin
                        vec_q       <= '0;
                        err_q       <= '0;
                        fail_seen_q <= 1'b0;
                        fail_vec_q  <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        hold_q      <= HOLD_INIT;
                        busy_q      <= 1'b1;
                        vld_q       <= 1'b1;
                        state_q     <= first_state_d;
                    end
                end
                SETTLE: begin
                    if (hold_q <= 8'd1) begin
                        hold_q  <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch_d && !fail_seen_q) begin
                        fail_vec_q  <= vec_q;
                        fail_seen_q <= 1'b1;
                    end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    if (mismatch_d || last_vec_d) begin
`else
                    if (last_vec_d) begin
`endif
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + VEC_ONE;
                        hold_q  <= HOLD_INIT;
                        state_q <= first_state_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.vec_valid = vld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_seen = fail_seen_q;
    assign bus.fail_vec  = fail_vec_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: directed runs against modelled gates, scoreboard checks vectors and results.
module tb_gate_vector_sequencer;
    localparam int N = 2;

    typedef enum logic [1:0] {G_AND, G_ZERO, G_NAND, G_ONE} gate_t;

    typedef struct {
        int           done_cyc;
        logic [N:0]   err;
        logic         fs;
        logic [N-1:0] fv;
        logic         ps;
        logic [N-1:0] vec;
    } res_t;

    logic  clk = 1'b0;
    logic  rst;
    gate_t gate;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    res_t         res_q[$];
    logic [N-1:0] vec_exp_q[$];

    gate_vector_sequencer_if #(.N_INPUTS(N)) bus();

    gate_vector_sequencer #(
        .N_INPUTS   (N),
        .HOLD_CYCLES(1),
        .EXPECT_TT  (4'b1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign bus.dut_y = (gate == G_AND)  ? (&bus.vec_out) :
                       (gate == G_NAND) ? ~(&bus.vec_out) :
                       (gate == G_ONE);

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    // Monitor: pops one expected vector per newly presented vector, one result per done rise.
    logic         vld_prev  = 1'b0;
    logic         done_prev = 1'b0;
    logic [N-1:0] vec_prev  = '0;
    res_t         r;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vec_valid && (!vld_prev || bus.vec_out != vec_prev)) begin
                if (vec_exp_q.size() == 0) fail_now("vec_unexpected");
                else check("vec_seq", 32'(bus.vec_out), 32'(vec_exp_q.pop_front()));
            end
            if (bus.done && !done_prev) begin
                if (res_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    r = res_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(r.done_cyc));
                    check("err_count", 32'(bus.err_count), 32'(r.err));
                    check("fail_seen", 32'(bus.fail_seen), 32'(r.fs));
                    check("fail_vec", 32'(bus.fail_vec), 32'(r.fv));
                    check("pass", 32'(bus.pass), 32'(r.ps));
                    check("vec_final", 32'(bus.vec_out), 32'(r.vec));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    check("valid_at_done", 32'(bus.vec_valid), 32'd0);
                end
            end
        end
        vld_prev  = bus.vec_valid;
        done_prev = bus.done;
        vec_prev  = bus.vec_out;
    end

    task automatic wait_done();
        int n = 0;
        while (!(bus.done && !bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("done_timeout");
        @(negedge clk);
    endtask

    task automatic run(input gate_t g, input int lat, input logic [N:0] err, input logic fs,
                       input logic [N-1:0] fv, input logic ps, input logic [N-1:0] vlast,
                       input int nvec, input bit repulse);
        res_t e;
        gate = g;
        for (int i = 0; i < nvec; i++) vec_exp_q.push_back(i[N-1:0]);
        @(negedge clk);
        bus.start = 1'b1;
        e.done_cyc = cyc + 1 + lat;
        e.err = err; e.fs = fs; e.fv = fv; e.ps = ps; e.vec = vlast;
        res_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_valid", 32'(bus.vec_valid), 32'd1);
        check("start_clr_done", 32'(bus.done), 32'd0);
        check("start_clr_err", 32'(bus.err_count), 32'd0);
        check("start_clr_fs", 32'(bus.fail_seen), 32'd0);
        if (repulse) begin
            repeat (2) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        gate_t t5_gate;
        int    n;
        rst = 1'b1;
        bus.start = 1'b0;
        gate = G_AND;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.vec_valid), 32'd0);
        check("rst_err", 32'(bus.err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(G_AND,  9, 3'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4, 1'b0);
        run(G_ZERO, 9, 3'd1, 1'b1, 2'd3, 1'b0, 2'd3, 4, 1'b0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        run(G_NAND, 3, 3'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1, 1'b0);
`else
        run(G_NAND, 9, 3'd4, 1'b1, 2'd0, 1'b0, 2'd3, 4, 1'b0);
`endif
        run(G_ZERO, 9, 3'd1, 1'b1, 2'd3, 1'b0, 2'd3, 4, 1'b1);
        run(G_AND,  9, 3'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4, 1'b0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        run(G_ONE,  3, 3'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1, 1'b0);
        t5_gate = G_AND;
`else
        run(G_ONE,  9, 3'd3, 1'b1, 2'd0, 1'b0, 2'd3, 4, 1'b0);
        t5_gate = G_ONE;
`endif

        // Abort mid-run once vector 2 is on the bus.
        gate = t5_gate;
        for (int i = 0; i < 3; i++) vec_exp_q.push_back(i[N-1:0]);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.vec_out != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("abort_vec_timeout");
        #2 rst = 1'b1;
        #1;
        check("abort_vec", 32'(bus.vec_out), 32'd0);
        check("abort_valid", 32'(bus.vec_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_err", 32'(bus.err_count), 32'd0);
        check("abort_fs", 32'(bus.fail_seen), 32'd0);
        check("abort_fv", 32'(bus.fail_vec), 32'd0);
        check("abort_pass", 32'(bus.pass), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(G_AND, 9, 3'd0, 1'b0, 2'd0, 1'b1, 2'd3, 4, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_results_left", 32'(res_q.size()), 32'd0);
        check("sb_vectors_left", 32'(vec_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
